// File: rtl/class_decider.sv
// Picks the most probable class from a 10-word IEEE-754 probability vector,
// flags winners below a confidence threshold and counts delivered results.
module class_decider (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_in,
  output logic        in_ready,
  input  logic [31:0] prob_in [9:0],
  input  logic [31:0] threshold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  class_idx,
  output logic [31:0] class_prob,
  output logic        low_conf,
  output logic [15:0] frame_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [3:0] LAST_PTR = 4'd9;

  // Maps a float onto an unsigned key whose ordering matches numeric order,
  // with +0 above -0 and any NaN below every number.
  function automatic logic [31:0] ord_key(input logic [31:0] f);
    if (f[30:23] == 8'hFF && f[22:0] != 23'd0)
      return 32'h0000_0000;
    else if (!f[31])
      return f | 32'h8000_0000;
    else
      return ~f;
  endfunction

  logic [1:0]  state;
  logic [31:0] samples [0:9];
  logic [31:0] thr_q;
  logic [31:0] best_key;
  logic [3:0]  best_idx;
  logic [3:0]  ptr;

  logic [31:0] cur_key;
  logic        take;
  logic [3:0]  scan_idx;
  logic [31:0] scan_key;

  assign in_ready = (state == IDLE);

  // Candidate winner after comparing the element under ptr; strict
  // greater-than keeps the lower index on ties.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no latch can be inferred.
    cur_key  = ord_key(samples[ptr]);
    take     = 1'b0;
    scan_idx = best_idx;
    scan_key = best_key;
    if (cur_key > best_key) begin
      take     = 1'b1;
      scan_idx = ptr;
      scan_key = cur_key;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      class_idx  <= 4'd0;
      class_prob <= 32'd0;
      low_conf   <= 1'b0;
      frame_cnt  <= 16'd0;
      thr_q      <= 32'd0;
      best_key   <= 32'd0;
      best_idx   <= 4'd0;
      ptr        <= 4'd0;
      // NOTE: the sample array is cleared on reset as well, so an aborted
      // frame leaves no stale probabilities behind.
      for (int i = 0; i < 10; i++) samples[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            for (int i = 0; i < 10; i++) samples[i] <= prob_in[i];
            thr_q    <= threshold;
            best_idx <= 4'd0;
            best_key <= ord_key(prob_in[0]);
            ptr      <= 4'd1;
            state    <= SCAN;
          end
        end

        SCAN: begin
          if (take) begin
            best_idx <= scan_idx;
            best_key <= scan_key;
          end
          ptr <= ptr + 4'd1;
          if (ptr == LAST_PTR) begin
            class_idx  <= scan_idx;
            class_prob <= samples[scan_idx];
            low_conf   <= (scan_key < ord_key(thr_q));
            out_valid  <= 1'b1;
            state      <= HOLD;
          end
        end

        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
